// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer for the iCE40 SB_PLL40.
// Holds the PLL in reset, waits for a stable LOCK, and then releases the
// system reset. It retries after a lock timeout, faults after too many
// retries, and re-sequences whenever lock is lost while running.
module pll_lock_sequencer #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES         = 3,
  localparam int RW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1),
  localparam int MAXA = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RESET_CYCLES : LOCK_STABLE_CYCLES,
  localparam int MAXC = (MAXA > LOCK_TIMEOUT_CYCLES) ? MAXA : LOCK_TIMEOUT_CYCLES,
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pll_lock,
  output logic          pll_resetb,
  output logic          sys_rst_n,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic          lock_meta, lock_s;
  logic          pll_resetb_reg, sys_rst_n_reg, ready_reg, fault_reg;

  // Two-flop synchronizer bringing the asynchronous PLL LOCK into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state, cycle counter and retry counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == CW'(PLL_RESET_CYCLES - 1)) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_next = '0;
          if (retry_reg == RW'(MAX_RETRIES)) begin
            state_next = ST_FAULT;
          end else begin
            state_next = ST_PLL_RST;
            retry_next = retry_reg + RW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_STABLE: begin
        // A lock drop restarts the timeout window without costing a retry.
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_next = ST_RUN;
          cnt_next   = '0;
          retry_next = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_next = ST_PLL_RST;
          cnt_next   = '0;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_PLL_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // State registers; outputs decode the next state so they move with STATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_PLL_RST;
      cnt_reg        <= '0;
      retry_reg      <= '0;
      pll_resetb_reg <= 1'b0;
      sys_rst_n_reg  <= 1'b0;
      ready_reg      <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      retry_reg      <= retry_next;
      pll_resetb_reg <= (state_next == ST_WAIT_LOCK) || (state_next == ST_STABLE) ||
                        (state_next == ST_RUN);
      sys_rst_n_reg  <= (state_next == ST_RUN);
      ready_reg      <= (state_next == ST_RUN);
      fault_reg      <= (state_next == ST_FAULT);
    end
  end

  assign pll_resetb = pll_resetb_reg;
  assign sys_rst_n  = sys_rst_n_reg;
  assign ready      = ready_reg;
  assign fault      = fault_reg;
  assign retry_cnt  = retry_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-with-random-timing bench for pll_lock_sequencer. Expected values
// are derived from elapsed cycle counts after each PLL_LOCK change.
module tb_pll_lock_sequencer;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 32;
  localparam int MR  = 2;

  // Public state numbering of the STATE output.
  localparam int S_RST = 0, S_WAIT = 1, S_STAB = 2, S_RUN = 3, S_FAULT = 4;

  // Edges from a PLL_LOCK change until the sequencer reacts to it.
  localparam int SYNC_REACT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_resetb, sys_rst_n, ready, fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES(PRC),
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES(MR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .pll_resetb(pll_resetb),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp))
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output check; the other outputs follow from the expected state.
  task automatic chk_all(input string tag, input int st, input int rc);
    chk({tag, ".state"}, 32'(state), st);
    chk({tag, ".pll_resetb"}, 32'(pll_resetb),
        (st == S_WAIT || st == S_STAB || st == S_RUN) ? 1 : 0);
    chk({tag, ".sys_rst_n"}, 32'(sys_rst_n), (st == S_RUN) ? 1 : 0);
    chk({tag, ".ready"}, 32'(ready), (st == S_RUN) ? 1 : 0);
    chk({tag, ".fault"}, 32'(fault), (st == S_FAULT) ? 1 : 0);
    chk({tag, ".retry_cnt"}, 32'(retry_cnt), rc);
    $display("step %-14s t=%0t state=%0d resetb=%0b sys=%0b rdy=%0b flt=%0b retry=%0d",
             tag, $time, state, pll_resetb, sys_rst_n, ready, fault, retry_cnt);
  endtask

  // Async reset in the middle of a clock phase, then synchronous release.
  task automatic mid_cycle_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(tag, S_RST, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int d, g, l, r;

    // 1) reset values and PLL reset pulse length
    #2;
    chk_all("reset", S_RST, 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 1; i < PRC; i++) begin
      tick(1);
      chk_all("pllrst_hold", S_RST, 0);
    end
    tick(1);
    chk_all("pllrst_done", S_WAIT, 0);

    // 4a) first timeout with lock held low
    tick(LTC - 1);
    chk_all("wait_pre_to1", S_WAIT, 0);
    tick(1);
    chk_all("timeout1", S_RST, 1);
    tick(PRC);
    chk_all("retry1_wait", S_WAIT, 1);

    // 2) lock arrives a random number of cycles into WAIT_LOCK
    d = $urandom_range(5, 20);
    tick(d);
    pll_lock = 1'b1;
    tick(SYNC_REACT - 1);
    chk_all("lock_syncing", S_WAIT, 1);
    tick(1);
    chk_all("stable_enter", S_STAB, 1);

    // 3) glitch during STABLE restarts the wait without a retry
    g = $urandom_range(1, 4);
    l = $urandom_range(1, 3);
    tick(g);
    pll_lock = 1'b0;
    tick(l);
    pll_lock = 1'b1;
    tick(2);
    chk_all("glitch_wait", S_WAIT, 1);
    tick(1);
    chk_all("glitch_restab", S_STAB, 1);
    tick(LSC - 1);
    chk_all("stable_window", S_STAB, 1);
    tick(1);
    chk_all("run_enter", S_RUN, 0);

    // 5) loss of lock in RUN and recovery
    r = $urandom_range(1, 10);
    tick(r);
    chk_all("run_hold", S_RUN, 0);
    pll_lock = 1'b0;
    tick(SYNC_REACT - 1);
    chk_all("run_lossync", S_RUN, 0);
    tick(1);
    chk_all("run_lost", S_RST, 0);
    pll_lock = 1'b1;
    tick(PRC - 1);
    chk_all("relock_pllrst", S_RST, 0);
    tick(1);
    chk_all("relock_wait", S_WAIT, 0);
    tick(1);
    chk_all("relock_stab", S_STAB, 0);
    tick(LSC);
    chk_all("relock_run", S_RUN, 0);

    // 6a) async reset while in RUN
    mid_cycle_reset("areset_run");
    tick(PRC + 1);
    chk_all("after_rst_stab", S_STAB, 0);

    // 6b) async reset while in STABLE
    tick(3);
    mid_cycle_reset("areset_stab");
    pll_lock = 1'b0;

    // lock arriving exactly on the timeout cycle wins
    tick(PRC);
    chk_all("bound_wait", S_WAIT, 0);
    tick(LTC - SYNC_REACT);
    pll_lock = 1'b1;
    tick(SYNC_REACT);
    chk_all("lock_wins", S_STAB, 0);

    // 4b) lock held low: timeouts to FAULT
    pll_lock = 1'b0;
    tick(SYNC_REACT);
    chk_all("drop_to_wait", S_WAIT, 0);
    for (int k = 0; k <= MR; k++) begin
      tick(LTC - 1);
      chk_all("to_pre", S_WAIT, k);
      tick(1);
      if (k < MR) begin
        chk_all("to_retry", S_RST, k + 1);
        tick(PRC);
        chk_all("to_rewait", S_WAIT, k + 1);
      end else begin
        chk_all("to_fault", S_FAULT, MR);
      end
    end
    pll_lock = 1'b1;
    tick(20);
    chk_all("fault_held", S_FAULT, MR);
    mid_cycle_reset("fault_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
